tow_score_fsm: RTL and testbench
================================

// Module: tow_score_fsm
// PURPOSE
// - Game core of Tug-of-War, directly upstream of the LED output mux. Turns two player buttons into a
//   one-hot rope position, detects the winner, and drives score[6:0] plus the 2-bit LED control code.
// - Sequence: lamp test, then play, then win display. A start pulse restarts the sequence.
// PARAMETERS
// - LAMP_CYCLES   default 25_000_000  clocks spent in lamp test after reset or restart (0.5 s at 50 MHz)
// - BLINK_CYCLES  default 12_500_000  half-period of the win blink, in clocks
// - CNT_W         default 26          shared timer width; must satisfy 2**CNT_W > max(LAMP_CYCLES, BLINK_CYCLES)
// PORTS
// - clk       in   1  system clock; all logic on rising edge
// - rst       in   1  reset, synchronous, active-high
// - btn_l     in   1  left player, debounced and synchronised level, active-high
// - btn_r     in   1  right player, debounced and synchronised level, active-high
// - start     in   1  single-cycle restart pulse
// - score     out  7  one-hot rope position; bit6 = left end, bit0 = right end; registered
// - led_ctrl  out  2  11 = all on (lamp), 10 = show score, 00 = dark; 01 is never driven; registered
// - winner    out  2  00 = none, 10 = left won, 01 = right won; registered
// BEHAVIOUR
// - Reset, synchronous and active-high:
//   - state = LAMP, score = 7'b0001000, led_ctrl = 2'b11, winner = 2'b00, timer = 0, blink phase = 0.
//   - Edge registers are set to 1, so a button already held at reset never counts as a press.
// - Press = rising edge of a button level: btn & ~btn_q. btn_q updates every cycle in every state.
//   - A held button gives exactly one press.
// - LAMP: led_ctrl = 11, score = center.
//   - timer counts 0..LAMP_CYCLES-1. On the last count: go to PLAY, led_ctrl = 10, timer = 0.
//   - Presses are ignored. start is ignored and the timer continues.
// - PLAY: led_ctrl = 10.
//   - Left press only: score <<= 1. Right press only: score >>= 1.
//   - Both pressed in the same cycle: no move.
//   - score updates on the clock edge after the press cycle (1-cycle latency from btn rising).
//   - A move that lands on bit6: go to WIN, winner = 10. A move that lands on bit0: go to WIN, winner = 01.
//     score and winner register on the same edge.
//   - score stays one-hot at all times and never shifts past an end.
// - WIN: score and winner are frozen; presses are ignored. led_ctrl depends on WIN_BLINK_EN (see CONFIGURATION).
// - start in PLAY or WIN: next cycle state = LAMP, led_ctrl = 11, score = center, winner = 00, timer = 0.
//   - start has priority over a press in the same cycle.
// - rst asserted mid-game: full reset values on the next edge, whatever the state or timer value.
// - Timer wrap: the timer is cleared on every state entry. Terminal count is compared with ==, never by overflow.
// CONFIGURATION
// - Macro TOW_WIN_BLINK_EN.
// - Defined: in WIN, led_ctrl starts at 10 and toggles 10 <-> 00 every BLINK_CYCLES clocks, using the shared timer.
// - Undefined: in WIN, led_ctrl holds 10. The blink phase register and its logic are not compiled.
// STRUCTURE
// - Package tow_pkg:
//   - LED_LAMP = 2'b11, LED_SCORE = 2'b10, LED_DARK = 2'b00
//   - state encoding: LAMP, PLAY, WIN
//   - SCORE_CENTER = 7'b0001000
//   - WIN_LEFT = 2'b10, WIN_RIGHT = 2'b01
// - Sub-module tow_edge_pulse: 1-bit registered rising-edge detector with synchronous set-to-1 reset.
//   Instantiated twice, once for btn_l and once for btn_r.
// - Top level: one 3-state FSM, one CNT_W timer, score shift register, output registers.
// TESTING (run with LAMP_CYCLES = 4, BLINK_CYCLES = 3)
// - Reset, then idle: led_ctrl = 11 and score = 0001000 for 4 cycles; then led_ctrl = 10, winner = 00.
// - In PLAY, btn_l held 10 cycles: score = 0010000 one cycle after the rise, with no further moves;
//   btn_r pulsed in the same cycle as a btn_l rise: score unchanged.
// - Three left presses from center: score = 1000000, winner = 10, state WIN; further presses leave score unchanged.
// - Three right presses from center: score = 0000001, winner = 01; with TOW_WIN_BLINK_EN, led_ctrl
//   sequence is 10,10,10,00,00,00,10...; without the macro, led_ctrl holds 10.
// - start in WIN: next cycle led_ctrl = 11, score = 0001000, winner = 00; start during LAMP does not extend the lamp.
// - btn_l held through reset and lamp: no move in PLAY until it is released and pressed again;
//   rst asserted mid-PLAY gives reset values on the next edge.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and constants for the Tug-of-War game core.
package tow_pkg;

    typedef enum logic [1:0] {
        ST_LAMP = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2
    } tow_state_e;

    localparam logic [1:0] LED_LAMP     = 2'b11;
    localparam logic [1:0] LED_SCORE    = 2'b10;
    localparam logic [1:0] LED_DARK     = 2'b00;
    localparam logic [6:0] SCORE_CENTER = 7'b0001000;
    localparam logic [1:0] WIN_LEFT     = 2'b10;
    localparam logic [1:0] WIN_RIGHT    = 2'b01;
    localparam logic [1:0] WIN_NONE     = 2'b00;

    // Winner code for a rope position: left end is bit6, right end is bit0.
    function automatic logic [1:0] win_code(input logic [6:0] pos);
        if (pos[6]) begin
            return WIN_LEFT;
        end else if (pos[0]) begin
            return WIN_RIGHT;
        end else begin
            return WIN_NONE;
        end
    endfunction

endpackage

// File: rtl/tow_edge_pulse.sv
// Rising-edge detector for one debounced button level; previous level presets to 1 on reset.
module tow_edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_lvl,
    output logic o_press
);

    logic r_q;

    // Previous-level register; preset so a level held through reset never counts as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b1;
        end else begin
            r_q <= i_lvl;
        end
    end

    assign o_press = i_lvl & ~r_q;

endmodule

// File: rtl/tow_score_fsm.sv
// Tug-of-War game core: lamp test, play, win display. Optional win blink under TOW_WIN_BLINK_EN.
module tow_score_fsm
    import tow_pkg::*;
#(
    parameter int unsigned LAMP_CYCLES  = 25_000_000,
    parameter int unsigned BLINK_CYCLES = 12_500_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       start,
    output logic [6:0] score,
    output logic [1:0] led_ctrl,
    output logic [1:0] winner
);

    localparam logic [CNT_W-1:0] LAMP_LAST  = CNT_W'(LAMP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 32'd1);

    tow_state_e       r_state, w_state_nx;
    logic [CNT_W-1:0] r_timer, w_timer_nx;
    logic [6:0]       r_score, w_score_nx, w_shift;
    logic [1:0]       r_led, w_led_nx;
    logic [1:0]       r_winner, w_winner_nx;
    logic             w_press_l, w_press_r;
`ifdef TOW_WIN_BLINK_EN
    logic             r_phase, w_phase_nx;
`endif

    tow_edge_pulse u_edge_l (
        .clk     (clk),
        .rst     (rst),
        .i_lvl   (btn_l),
        .o_press (w_press_l)
    );

    tow_edge_pulse u_edge_r (
        .clk     (clk),
        .rst     (rst),
        .i_lvl   (btn_r),
        .o_press (w_press_r)
    );

    // Next-state, timer, rope and output-register logic.
    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = r_timer;
        w_score_nx  = r_score;
        w_led_nx    = r_led;
        w_winner_nx = r_winner;
        w_shift     = r_score;
`ifdef TOW_WIN_BLINK_EN
        w_phase_nx  = r_phase;
`endif
        if ((r_state != ST_LAMP) && start) begin
            // start outranks any press in the same cycle
            w_state_nx  = ST_LAMP;
            w_timer_nx  = '0;
            w_score_nx  = SCORE_CENTER;
            w_led_nx    = LED_LAMP;
            w_winner_nx = WIN_NONE;
`ifdef TOW_WIN_BLINK_EN
            w_phase_nx  = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_LAMP: begin
                    w_score_nx = SCORE_CENTER;
                    if (r_timer == LAMP_LAST) begin
                        w_state_nx = ST_PLAY;
                        w_led_nx   = LED_SCORE;
                        w_timer_nx = '0;
                    end else begin
                        w_led_nx   = LED_LAMP;
                        w_timer_nx = r_timer + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    w_led_nx = LED_SCORE;
                    if (w_press_l && !w_press_r) begin
                        w_shift = r_score << 1;
                    end else if (w_press_r && !w_press_l) begin
                        w_shift = r_score >> 1;
                    end else begin
                        w_shift = r_score;
                    end
                    w_score_nx = w_shift;
                    if (w_shift[6] || w_shift[0]) begin
                        w_state_nx  = ST_WIN;
                        w_winner_nx = win_code(w_shift);
                        w_timer_nx  = '0;
`ifdef TOW_WIN_BLINK_EN
                        w_phase_nx  = 1'b0;
`endif
                    end else begin
                        w_state_nx = ST_PLAY;
                    end
                end
                ST_WIN: begin
                    if (r_timer == BLINK_LAST) begin
                        w_timer_nx = '0;
`ifdef TOW_WIN_BLINK_EN
                        w_phase_nx = ~r_phase;
                        w_led_nx   = r_phase ? LED_SCORE : LED_DARK;
`else
                        w_led_nx   = LED_SCORE;
`endif
                    end else begin
                        w_timer_nx = r_timer + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx  = ST_LAMP;
                    w_timer_nx  = '0;
                    w_score_nx  = SCORE_CENTER;
                    w_led_nx    = LED_LAMP;
                    w_winner_nx = WIN_NONE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_LAMP;
            r_timer  <= '0;
            r_score  <= SCORE_CENTER;
            r_led    <= LED_LAMP;
            r_winner <= WIN_NONE;
`ifdef TOW_WIN_BLINK_EN
            r_phase  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_timer  <= w_timer_nx;
            r_score  <= w_score_nx;
            r_led    <= w_led_nx;
            r_winner <= w_winner_nx;
`ifdef TOW_WIN_BLINK_EN
            r_phase  <= w_phase_nx;
`endif
        end
    end

    assign score    = r_score;
    assign led_ctrl = r_led;
    assign winner   = r_winner;

endmodule

// File: tb/tb_tow_score_fsm.sv
// Randomised and directed bench for tow_score_fsm against a position/cycle-count reference model.
module tb_tow_score_fsm;

    localparam int LAMP  = 4;
    localparam int BLINK = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic       start = 1'b0;
    logic [6:0] score;
    logic [1:0] led_ctrl;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 lamp, 1 play, 2 win; pos = index of lit rope bit; cnt = cycles in mode
    int         m_mode = 0;
    int         m_pos  = 3;
    int         m_cnt  = 0;
    logic [1:0] m_win  = 2'b00;
    logic       m_ql   = 1'b1;
    logic       m_qr   = 1'b1;

    tow_score_fsm #(
        .LAMP_CYCLES  (LAMP),
        .BLINK_CYCLES (BLINK),
        .CNT_W        (26)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_l    (btn_l),
        .btn_r    (btn_r),
        .start    (start),
        .score    (score),
        .led_ctrl (led_ctrl),
        .winner   (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] m_expect();
        logic [6:0] s;
        logic [1:0] led;
        s = 7'b0000001 << m_pos;
        if (m_mode == 0) begin
            led = 2'b11;
        end else if (m_mode == 1) begin
            led = 2'b10;
        end else begin
`ifdef TOW_WIN_BLINK_EN
            led = (((m_cnt / BLINK) % 2) == 0) ? 2'b10 : 2'b00;
`else
            led = 2'b10;
`endif
        end
        return {s, led, m_win};
    endfunction

    task automatic model_edge(input logic l, input logic r, input logic s, input logic rs);
        logic pl, pr;
        pl = l & ~m_ql;
        pr = r & ~m_qr;
        if (rs) begin
            m_mode = 0; m_pos = 3; m_cnt = 0; m_win = 2'b00; m_ql = 1'b1; m_qr = 1'b1;
            return;
        end
        m_ql = l;
        m_qr = r;
        if (m_mode != 0 && s) begin
            m_mode = 0; m_pos = 3; m_cnt = 0; m_win = 2'b00;
        end else if (m_mode == 0) begin
            m_cnt++;
            if (m_cnt == LAMP) begin
                m_mode = 1; m_cnt = 0;
            end
        end else if (m_mode == 1) begin
            if (pl && !pr) m_pos++;
            else if (pr && !pl) m_pos--;
            if (m_pos == 6) begin
                m_mode = 2; m_cnt = 0; m_win = 2'b10;
            end else if (m_pos == 0) begin
                m_mode = 2; m_cnt = 0; m_win = 2'b01;
            end
        end else begin
            m_cnt++;
        end
    endtask

    task automatic step(input logic l, input logic r, input logic s, input logic rs);
        btn_l = l; btn_r = r; start = s; rst = rs;
        @(posedge clk);
        model_edge(l, r, s, rs);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({score, led_ctrl, winner} !== {7'b0001000, 2'b11, 2'b00}) begin
            errors++;
            $display("FAIL reset_values got %b exp %b", {score, led_ctrl, winner}, {7'b0001000, 2'b11, 2'b00});
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({score, led_ctrl} !== {7'b0001000, 2'b11}) begin
                errors++;
                $display("FAIL lamp_hold cyc %0d got %b exp %b", i, {score, led_ctrl}, {7'b0001000, 2'b11});
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({led_ctrl, winner} !== {2'b10, 2'b00}) begin
            errors++;
            $display("FAIL lamp_to_play got %b exp %b", {led_ctrl, winner}, {2'b10, 2'b00});
        end
    endtask

    task automatic test_held();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (score !== 7'b0010000) begin
            errors++;
            $display("FAIL held_first_move got %b exp %b", score, 7'b0010000);
        end
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (score !== 7'b0010000) begin
                errors++;
                $display("FAIL held_no_repeat cyc %0d got %b exp %b", i, score, 7'b0010000);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (score !== 7'b0010000) begin
            errors++;
            $display("FAIL both_pressed got %b exp %b", score, 7'b0010000);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic restart_to_play();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < LAMP; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_left_win();
        restart_to_play();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if ({score, winner} !== {7'b1000000, 2'b10}) begin
            errors++;
            $display("FAIL left_win got %b exp %b", {score, winner}, {7'b1000000, 2'b10});
        end
        for (int i = 0; i < 4; i++) begin
            step(i[0], ~i[0], 1'b0, 1'b0);
            checks++;
            if ({score, winner} !== {7'b1000000, 2'b10}) begin
                errors++;
                $display("FAIL win_frozen cyc %0d got %b exp %b", i, {score, winner}, {7'b1000000, 2'b10});
            end
        end
    endtask

    task automatic test_right_win_start();
        logic [1:0] seq [8];
`ifdef TOW_WIN_BLINK_EN
        seq = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
`else
        seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
        restart_to_play();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({score, winner, led_ctrl} !== {7'b0000001, 2'b01, seq[i]}) begin
                errors++;
                $display("FAIL right_win_led cyc %0d got %b exp %b", i, {score, winner, led_ctrl}, {7'b0000001, 2'b01, seq[i]});
            end
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({score, led_ctrl, winner} !== {7'b0001000, 2'b11, 2'b00}) begin
            errors++;
            $display("FAIL start_in_win got %b exp %b", {score, led_ctrl, winner}, {7'b0001000, 2'b11, 2'b00});
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (led_ctrl !== 2'b11) begin
            errors++;
            $display("FAIL lamp_last_cycle got %b exp %b", led_ctrl, 2'b11);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (led_ctrl !== 2'b10) begin
            errors++;
            $display("FAIL start_no_extend got %b exp %b", led_ctrl, 2'b10);
        end
    endtask

    task automatic test_held_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < LAMP + 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (score !== 7'b0001000) begin
                errors++;
                $display("FAIL held_through_reset cyc %0d got %b exp %b", i, score, 7'b0001000);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (score !== 7'b0010000) begin
            errors++;
            $display("FAIL repress_after_hold got %b exp %b", score, 7'b0010000);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({score, led_ctrl, winner} !== {7'b0001000, 2'b11, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_play got %b exp %b", {score, led_ctrl, winner}, {7'b0001000, 2'b11, 2'b00});
        end
    endtask

    task automatic test_random();
        logic l, r, s, rs;
        for (int i = 0; i < 3000; i++) begin
            l  = ($urandom_range(0, 2) == 0) ? ~btn_l : btn_l;
            r  = ($urandom_range(0, 2) == 0) ? ~btn_r : btn_r;
            s  = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 399) == 0);
            step(l, r, s, rs);
            checks++;
            if ({score, led_ctrl, winner} !== m_expect()) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", i, {score, led_ctrl, winner}, m_expect());
            end
        end
    endtask

    initial begin
        test_reset();
        test_held();
        test_left_win();
        test_right_win_start();
        test_held_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
